// File: rtl/addsub_digit_serial.sv
// Digit-serial two's-complement adder/subtractor, LSB digit first.
// Ports: AddSub_i_* clk/rst/start/A/B/fSub; AddSub_o_* Busy/Done/S/C/V.
// Optional: ADDSUB_SAT_EN clamps S on signed overflow.
module addsub_digit_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             AddSub_i_Clk,
  input  logic             AddSub_i_Rst,
  input  logic             AddSub_i_Start,
  input  logic [WIDTH-1:0] AddSub_i_A,
  input  logic [WIDTH-1:0] AddSub_i_B,
  input  logic             AddSub_i_fSub,
  output logic             AddSub_o_Busy,
  output logic             AddSub_o_Done,
  output logic [WIDTH-1:0] AddSub_o_S,
  output logic             AddSub_o_C,
  output logic             AddSub_o_V
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             c_q, c_d;
  logic             v_q, v_d;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] s_fin;
  logic             last;
  logic             accept;
  logic             v_raw;

  always_comb begin
    dsum = {1'b0, a_q[DIGIT-1:0]}
         + {1'b0, b_q[DIGIT-1:0]}
         + {{DIGIT{1'b0}}, carry_q};
    // New digit enters at the MSB end.
    acc_nxt = (acc_q >> DIGIT)
            | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
    last   = (cnt_q == CW'(NDIG - 1));
    accept = AddSub_i_Start && (state_q != S_RUN);
    // Carry into the MSB is recovered as a^b^sum at that bit.
    v_raw  = a_q[DIGIT-1] ^ b_q[DIGIT-1]
           ^ dsum[DIGIT-1] ^ dsum[DIGIT];
    s_fin  = acc_nxt;
`ifdef ADDSUB_SAT_EN
    // On the final digit a_q[DIGIT-1] is A's sign bit.
    if (v_raw) begin
      s_fin = a_q[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                           : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    s_d     = s_q;
    c_d     = c_q;
    v_d     = v_q;
    case (state_q)
      S_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = acc_nxt;
        carry_d = dsum[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          state_d = S_DONE;
          cnt_d   = '0;
          s_d     = s_fin;
          c_d     = dsum[DIGIT];
          v_d     = v_raw;
        end
      end
      default: begin
        if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
        if (accept) begin
          state_d = S_RUN;
          cnt_d   = '0;
          a_d     = AddSub_i_A;
          b_d     = AddSub_i_fSub ? ~AddSub_i_B
                                  : AddSub_i_B;
          carry_d = AddSub_i_fSub;
        end
      end
    endcase
  end

  always_ff @(posedge AddSub_i_Clk) begin
    if (AddSub_i_Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      c_q     <= c_d;
      v_q     <= v_d;
    end
  end

  assign AddSub_o_Busy = (state_q == S_RUN);
  assign AddSub_o_Done = (state_q == S_DONE);
  assign AddSub_o_S    = s_q;
  assign AddSub_o_C    = c_q;
  assign AddSub_o_V    = v_q;

endmodule

// File: tb/tb_addsub_digit_serial.sv
// Bench for addsub_digit_serial: DIGIT=4, 16 and 1 builds
// driven in parallel from shared inputs.
module tb_addsub_digit_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        fsub;
  logic [15:0] a, b;
  logic [2:0]  busy, done, c, v;
  logic [15:0] s0, s1, s2;

  int checks = 0;
  int errors = 0;
  int nd[3] = '{4, 16, 1};

  logic [15:0] r_s[3];
  logic        r_c[3], r_v[3];
  int          r_lat[3], r_busy[3], r_dcnt[3];

  always #5 clk = ~clk;

  addsub_digit_serial #(.WIDTH(16), .DIGIT(4)) u0 (
    .AddSub_i_Clk(clk), .AddSub_i_Rst(rst),
    .AddSub_i_Start(start), .AddSub_i_A(a),
    .AddSub_i_B(b), .AddSub_i_fSub(fsub),
    .AddSub_o_Busy(busy[0]), .AddSub_o_Done(done[0]),
    .AddSub_o_S(s0), .AddSub_o_C(c[0]), .AddSub_o_V(v[0])
  );

  addsub_digit_serial #(.WIDTH(16), .DIGIT(1)) u1 (
    .AddSub_i_Clk(clk), .AddSub_i_Rst(rst),
    .AddSub_i_Start(start), .AddSub_i_A(a),
    .AddSub_i_B(b), .AddSub_i_fSub(fsub),
    .AddSub_o_Busy(busy[1]), .AddSub_o_Done(done[1]),
    .AddSub_o_S(s1), .AddSub_o_C(c[1]), .AddSub_o_V(v[1])
  );

  addsub_digit_serial #(.WIDTH(16), .DIGIT(16)) u2 (
    .AddSub_i_Clk(clk), .AddSub_i_Rst(rst),
    .AddSub_i_Start(start), .AddSub_i_A(a),
    .AddSub_i_B(b), .AddSub_i_fSub(fsub),
    .AddSub_o_Busy(busy[2]), .AddSub_o_Done(done[2]),
    .AddSub_o_S(s2), .AddSub_o_C(c[2]), .AddSub_o_V(v[2])
  );

  function automatic logic [15:0] sel_s(input int i);
    case (i)
      0:       return s0;
      1:       return s1;
      default: return s2;
    endcase
  endfunction

  // Reference: {C, V, S}
  function automatic logic [17:0] model(
    input logic [15:0] ma, input logic [15:0] mb,
    input logic msub);
    logic [15:0] be;
    logic [16:0] t;
    logic [15:0] ms;
    logic        mv;
    be = msub ? ~mb : mb;
    t  = {1'b0, ma} + {1'b0, be} + {16'd0, msub};
    ms = t[15:0];
    mv = (ma[15] == be[15]) && (ms[15] != ma[15]);
`ifdef ADDSUB_SAT_EN
    if (mv) ms = ma[15] ? 16'h8000 : 16'h7FFF;
`endif
    return {t[16], mv, ms};
  endfunction

  task automatic run_op(input logic [15:0] ia,
                        input logic [15:0] ib,
                        input logic isub);
    @(negedge clk);
    a = ia; b = ib; fsub = isub; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~ia; b = ~ib; fsub = ~isub;
    for (int i = 0; i < 3; i++) begin
      r_lat[i] = 0; r_busy[i] = 0; r_dcnt[i] = 0;
    end
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 3; i++) begin
        if (busy[i]) r_busy[i]++;
        if (done[i]) begin
          if (r_dcnt[i] == 0) begin
            r_lat[i] = k;
            r_s[i] = sel_s(i);
            r_c[i] = c[i];
            r_v[i] = v[i];
          end
          r_dcnt[i]++;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_op(input string nm,
                          input logic [15:0] es,
                          input logic ec, input logic ev);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (r_dcnt[i] !== 1) begin
        errors++;
        $display("FAIL %s done_pulses[%0d]: got %0d expected 1",
                 nm, i, r_dcnt[i]);
      end
      checks++;
      if (r_lat[i] !== nd[i]) begin
        errors++;
        $display("FAIL %s latency[%0d]: got %0d expected %0d",
                 nm, i, r_lat[i], nd[i]);
      end
      checks++;
      if (r_busy[i] !== nd[i]) begin
        errors++;
        $display("FAIL %s busy_cycles[%0d]: got %0d expected %0d",
                 nm, i, r_busy[i], nd[i]);
      end
      checks++;
      if ({r_c[i], r_v[i], r_s[i]} !== {ec, ev, es}) begin
        errors++;
        $display("FAIL %s result[%0d]: got C=%b V=%b S=%h expected C=%b V=%b S=%h",
                 nm, i, r_c[i], r_v[i], r_s[i], ec, ev, es);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; fsub = 1'b0;
    a = 16'h0; b = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({busy[i], done[i], c[i], v[i], sel_s(i)} !== 20'h0) begin
        errors++;
        $display("FAIL reset[%0d]: got busy=%b done=%b C=%b V=%b S=%h expected all zero",
                 i, busy[i], done[i], c[i], v[i], sel_s(i));
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add;
    run_op(16'h1234, 16'h0FFF, 1'b0);
    check_op("add_1234_0fff", 16'h2233, 1'b0, 1'b0);
  endtask

  task automatic test_sub;
    run_op(16'h000A, 16'h000C, 1'b1);
    check_op("sub_borrow", 16'hFFFE, 1'b0, 1'b0);
    run_op(16'h0009, 16'h0008, 1'b1);
    check_op("sub_noborrow", 16'h0001, 1'b1, 1'b0);
  endtask

  task automatic test_overflow;
`ifdef ADDSUB_SAT_EN
    run_op(16'h7FFF, 16'h0001, 1'b0);
    check_op("pos_ovf", 16'h7FFF, 1'b0, 1'b1);
    run_op(16'h8000, 16'h0001, 1'b1);
    check_op("neg_ovf", 16'h8000, 1'b1, 1'b1);
`else
    run_op(16'h7FFF, 16'h0001, 1'b0);
    check_op("pos_ovf", 16'h8000, 1'b0, 1'b1);
    run_op(16'h8000, 16'h0001, 1'b1);
    check_op("neg_ovf", 16'h7FFF, 1'b1, 1'b1);
`endif
  endtask

  task automatic test_random;
    logic [15:0] ra, rb;
    logic        rs;
    logic [17:0] e;
    for (int n = 0; n < 30; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      e  = model(ra, rb, rs);
      run_op(ra, rb, rs);
      check_op("random", e[15:0], e[17], e[16]);
    end
  endtask

  task automatic test_back_to_back;
    logic [17:0] expq[$];
    logic [17:0] e;
    int last_done = -1;
    int ndone = 0;
    for (int cyc = 0; cyc < 35; cyc++) begin
      @(negedge clk);
      if (cyc < 20) begin
        start = 1'b1;
        a = 16'($urandom);
        b = 16'($urandom);
        fsub = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      if (start && !busy[0]) expq.push_back(model(a, b, fsub));
      @(posedge clk);
      #1;
      if (done[0]) begin
        ndone++;
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL b2b_result: got done with no accepted op expected none");
        end else begin
          e = expq.pop_front();
          if ({c[0], v[0], s0} !== e) begin
            errors++;
            $display("FAIL b2b_result: got %h expected %h",
                     {c[0], v[0], s0}, e);
          end
        end
        if (last_done >= 0) begin
          checks++;
          if (cyc - last_done !== 5) begin
            errors++;
            $display("FAIL b2b_interval: got %0d expected 5",
                     cyc - last_done);
          end
        end
        last_done = cyc;
      end
    end
    checks++;
    if (ndone !== 4 || expq.size() !== 0) begin
      errors++;
      $display("FAIL b2b_count: got %0d done, %0d pending expected 4, 0",
               ndone, expq.size());
    end
  endtask

  task automatic test_reset_mid;
    int ndone;
    @(negedge clk);
    a = 16'h1234; b = 16'h0FFF; fsub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({busy[i], done[i], c[i], v[i], sel_s(i)} !== 20'h0) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got busy=%b done=%b C=%b V=%b S=%h expected all zero",
                 i, busy[i], done[i], c[i], v[i], sel_s(i));
      end
    end
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done[0] || done[1]) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d pulses expected 0",
               ndone);
    end
    run_op(16'h0009, 16'h0008, 1'b1);
    check_op("after_reset", 16'h0001, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_random();
    test_back_to_back();
    repeat (20) @(posedge clk);
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
